// File: rtl/rr_arb_if.sv
// Request/grant bundle between a set of requesters and the rr_arb arbiter.
// Handshake: requester i raises req[i] and keeps it high until it sees gnt[i]
// at the arbiter's registered output. gnt is one-hot or zero, and gnt_idx and
// gnt_valid always describe the same grant. A dropped request is never granted.
interface rr_arb_if #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) ();
  logic [WIDTH-1:0] req;
  logic             en;
  logic             rr_mode;
  logic             hold;
  logic [WIDTH-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  // Requester side: drives requests and mode controls, observes the grant.
  modport master (
    output req, en, rr_mode, hold,
    input  gnt, gnt_idx, gnt_valid
  );

  // Arbiter side.
  modport slave (
    input  req, en, rr_mode, hold,
    output gnt, gnt_idx, gnt_valid
  );
endinterface

// File: rtl/rr_arb.sv
// Registered priority arbiter for WIDTH requesters (legal WIDTH: 2..32).
// It has two modes: fixed priority, where the highest index wins, and
// round-robin, which searches downward from a rotating pointer. It also has an
// optional grant hold. All outputs come straight from flops, so no input
// reaches an output combinationally. dbg_ptr exposes the round-robin pointer.
module rr_arb #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  rr_arb_if.slave          bus,
  output logic [IDX_W-1:0] dbg_ptr
);

  logic [WIDTH-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [IDX_W-1:0] fp_k;
  logic [IDX_W-1:0] rr_k;
  logic             rr_found;
  logic             hold_hit;

  // Returns (p - n) mod WIDTH for p < WIDTH and n <= WIDTH.
  function automatic logic [IDX_W-1:0] wrap_sub(input logic [IDX_W-1:0] p,
                                                input int unsigned n);
    int unsigned v;
    v = 32'(p) + 32'(WIDTH) - n;
    if (v >= 32'(WIDTH)) v = v - 32'(WIDTH);
    return IDX_W'(v);
  endfunction

  // Fixed priority: the highest set request index wins. The last match in the loop is kept.
  always_comb begin
    fp_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.req[i]) fp_k = IDX_W'(i);
    end
  end

  // Round-robin: the candidate index steps down from ptr and wraps, so the first hit wins.
  always_comb begin
    rr_k     = '0;
    rr_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!rr_found && bus.req[wrap_sub(ptr_q, i)]) begin
        rr_found = 1'b1;
        rr_k     = wrap_sub(ptr_q, i);
      end
    end
  end

  assign hold_hit = bus.hold && ((gnt_q & bus.req) != '0);

  // Next-state selection. Disable beats hold, hold beats idle, and idle beats the two arbitration modes.
  always_comb begin
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    if (!bus.en || (!hold_hit && bus.req == '0)) begin
      gnt_d       = '0;
      gnt_idx_d   = '0;
      gnt_valid_d = 1'b0;
    end else if (!hold_hit) begin
      gnt_d       = '0;
      gnt_valid_d = 1'b1;
      if (!bus.rr_mode) begin
        gnt_d[fp_k] = 1'b1;
        gnt_idx_d   = fp_k;
      end else begin
        gnt_d[rr_k] = 1'b1;
        gnt_idx_d   = rr_k;
        ptr_d       = wrap_sub(rr_k, 1);
      end
    end
  end

  // State registers. Reset puts the pointer at the top index, so the highest index is granted first.
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= IDX_W'(WIDTH - 1);
    end else begin
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_rr_arb.sv
// Directed bench for rr_arb at WIDTH = 4, with hand-computed expectations.
// A monitor also checks the grant invariants on every falling edge.
module tb_rr_arb;

  localparam int WIDTH = 4;
  localparam int IDX_W = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [IDX_W-1:0] dbg_ptr;
  int               checks = 0;
  int               errors = 0;
  logic             mon_en = 1'b0;
  logic [WIDTH-1:0] req_prev = '0;

  rr_arb_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  rr_arb #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus.slave),
    .dbg_ptr (dbg_ptr)
  );

  // Clock.
  always #5 clock = ~clock;

  // Request vector seen at each rising edge.
  always @(posedge clock) req_prev <= bus.req;

  // Invariant monitor, sampled away from the active edge.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      assert ((bus.gnt & (bus.gnt - 4'd1)) === 4'd0) else begin
        errors++;
        $error("FAIL onehot0: got %b required one-hot or zero", bus.gnt);
      end
      checks++;
      assert (bus.gnt_valid === (|bus.gnt)) else begin
        errors++;
        $error("FAIL valid_or: got %b required %b", bus.gnt_valid, |bus.gnt);
      end
      checks++;
      assert ((bus.gnt & ~req_prev) === 4'd0) else begin
        errors++;
        $error("FAIL subset: gnt %b not within previous req %b", bus.gnt, req_prev);
      end
    end
  end

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  // Check grant vector, index and valid together.
  task automatic chk_gnt(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_idx);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(exp_gnt));
    chk({tag, "_idx"}, 32'(bus.gnt_idx), 32'(exp_idx));
    chk({tag, "_valid"}, 32'(bus.gnt_valid), 32'(exp_gnt != 4'd0));
  endtask

  logic [3:0] fp_req [9];
  logic [3:0] fp_gnt [9];
  logic [1:0] fp_idx [9];
  logic [3:0] rot_gnt [6];
  logic [1:0] rot_idx [6];

  initial begin
    fp_req  = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0101, 4'b0110, 4'b1110, 4'b1111};
    fp_gnt  = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    fp_idx  = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd3};
    rot_gnt = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
    rot_idx = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};

    // Reset with full requests pending.
    reset       = 1'b1;
    bus.req     = 4'b1111;
    bus.en      = 1'b1;
    bus.rr_mode = 1'b1;
    bus.hold    = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    chk_gnt("reset", 4'b0000, 2'd0);
    chk("reset_ptr", 32'(dbg_ptr), 32'd3);

    // Round-robin rotation from reset.
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_gnt($sformatf("rot%0d", i), rot_gnt[i], rot_idx[i]);
    end
    chk("rot_ptr", 32'(dbg_ptr), 32'd1);

    // Disable for two cycles: grant drops and the pointer is kept.
    bus.en = 1'b0;
    tick();
    chk_gnt("en_off0", 4'b0000, 2'd0);
    tick();
    chk_gnt("en_off1", 4'b0000, 2'd0);
    chk("en_off_ptr", 32'(dbg_ptr), 32'd1);
    bus.en = 1'b1;
    tick();
    chk_gnt("en_resume", 4'b0010, 2'd1);
    chk("resume_ptr", 32'(dbg_ptr), 32'd0);

    // Wrap and skip from ptr = 0.
    bus.req = 4'b1010;
    tick();
    chk_gnt("wrap", 4'b1000, 2'd3);
    tick();
    chk_gnt("skip", 4'b0010, 2'd1);
    chk("skip_ptr", 32'(dbg_ptr), 32'd0);

    // Fixed priority, matching the old ps4 behaviour.
    bus.rr_mode = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.req = fp_req[i];
      tick();
      chk_gnt($sformatf("fp%0d", i), fp_gnt[i], fp_idx[i]);
    end
    chk("fp_ptr", 32'(dbg_ptr), 32'd0);

    // Back to round-robin: resumes from the retained ptr = 0.
    bus.rr_mode = 1'b1;
    tick();
    chk_gnt("mode_back", 4'b0001, 2'd0);
    chk("mode_back_ptr", 32'(dbg_ptr), 32'd3);

    // Idle, then hold on requester 2.
    bus.req = 4'b0000;
    tick();
    chk_gnt("idle", 4'b0000, 2'd0);
    bus.hold = 1'b1;
    bus.req  = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_gnt($sformatf("hold%0d", i), 4'b0100, 2'd2);
    end
    chk("hold_ptr", 32'(dbg_ptr), 32'd1);

    // Hold break: the grantee drops its request.
    bus.req = 4'b0001;
    tick();
    chk_gnt("hold_break", 4'b0001, 2'd0);

    // Disable overrides hold.
    bus.en = 1'b0;
    tick();
    chk_gnt("en_vs_hold", 4'b0000, 2'd0);
    bus.en = 1'b1;
    tick();
    chk_gnt("rehold", 4'b0001, 2'd0);
    bus.req = 4'b1111;
    tick();
    chk_gnt("hold_keep", 4'b0001, 2'd0);

    // Reset in the middle of a hold.
    reset = 1'b1;
    tick();
    chk_gnt("reset_hold", 4'b0000, 2'd0);
    chk("reset_hold_ptr", 32'(dbg_ptr), 32'd3);
    reset    = 1'b0;
    bus.hold = 1'b0;
    tick();
    chk_gnt("post_reset", 4'b1000, 2'd3);
    tick();
    chk_gnt("post_reset2", 4'b0100, 2'd2);

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb.md
# rr_arb

Parametrised registered priority arbiter: successor to the 4-bit combinational priority selector `ps4`. It grants one of `WIDTH` requesters per cycle in either fixed-priority or round-robin mode, with an optional grant hold. It sits in front of shared resources (e.g. a shared bus or functional unit) in the pipeline. The grant is registered, so the block's output can feed downstream logic directly without a long combinational path.

## Interface
- `WIDTH`, default 4: number of requesters; legal range is 2..32.
- `IDX_W`, default `$clog2(WIDTH)`: width of the granted-index output.
- `clock`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req`, input, `WIDTH`: request vector; bit i = requester i.
- `en`, input, 1: arbitration enable.
- `rr_mode`, input, 1: 1 = round-robin, 0 = fixed priority (highest index wins).
- `hold`, input, 1: when 1, the current grantee keeps its grant while it keeps requesting.
- `gnt`, output, `WIDTH`: registered grant vector; either one-hot or all zeros.
- `gnt_idx`, output, `IDX_W`: binary index of the set `gnt` bit; 0 when `gnt_valid` = 0.
- `gnt_valid`, output, 1: 1 iff `gnt` is non-zero.

## Operation
- Internal state:
  - `gnt` register.
  - Priority pointer `ptr` (`IDX_W` bits): the index that has highest priority in the next round-robin search.
- Reset values: `gnt` = 0, `gnt_idx` = 0, `gnt_valid` = 0, `ptr` = `WIDTH`-1.
- Each rising edge applies the first matching rule, in this order:
  1. `reset` = 1: load the reset values.
  2. `en` = 0: `gnt` <= 0; `ptr` unchanged.
  3. `hold` = 1 and `(gnt & req)` != 0: `gnt` unchanged; `ptr` unchanged.
  4. `req` = 0: `gnt` <= 0; `ptr` unchanged.
  5. `rr_mode` = 0: grant the highest set index of `req`; `ptr` unchanged.
  6. `rr_mode` = 1: search downward from `ptr` (ptr, ptr-1, …, 0, then wrap to `WIDTH`-1, …, ptr+1). Grant the first set bit k. Then `ptr` <= (k-1) mod `WIDTH`, i.e. k=0 wraps to `WIDTH`-1.
- `gnt_idx` and `gnt_valid` are registered together with `gnt` and are always consistent with it.
- Round-robin fairness: with all requesters continuously requesting and `hold` = 0, each requester is granted exactly once every `WIDTH` cycles.
- Mode change (`rr_mode` toggling): takes effect at the next edge. `ptr` is retained across fixed-mode cycles, and round-robin resumes from the retained `ptr`.
- Hold break: if the grantee drops its request in the same cycle that `hold` = 1, rule 3 fails. Normal arbitration (rules 4-6) applies at that edge, and the dropped requester may not be re-granted that edge because its request is 0.
- Reset mid-hold or mid-rotation: everything returns to the reset values at that edge, so the first round-robin grant afterwards goes to the highest-index requester.
- `en` = 0 overrides `hold`.

## Timing
- Latency: `req`, `en`, `hold` and `rr_mode` sampled at edge n determine `gnt` after edge n; the result is visible for the whole cycle n to n+1.
- There is no combinational path from any input to any output.
- Requesters must hold `req` until they observe their `gnt` bit. Grant loss when a request is dropped before being granted is the requester's responsibility.
- The search is a single cycle for any legal `WIDTH`. Implement it as a rotate, priority-encode, unrotate, or as a double-width priority encoder.

## Test plan
All scenarios use `WIDTH` = 4.
- **Reset:** hold `reset` = 1 for 2 edges with `req` = 1111 and `en` = 1 -> `gnt` = 0000, `gnt_valid` = 0, `gnt_idx` = 0. After release, the first grant is 1000.
- **Fixed priority (`ps4` equivalence):** `rr_mode` = 0, `en` = 1, `hold` = 0; drive `req` through 0000, 1000, 0100, 0010, 0001, 0101, 0110, 1110, 1111, one per cycle -> the `gnt` observed one edge later is 0000, 1000, 0100, 0010, 0001, 0100, 0100, 1000, 1000.
- **Round-robin rotation:** after reset, `rr_mode` = 1 and `req` = 1111 held for 6 cycles -> `gnt` = 1000, 0100, 0010, 0001, 1000, 0100, with `gnt_idx` = 3, 2, 1, 0, 3, 2.
- **Wrap and skip:** from a state with `ptr` = 0 (reached after granting 0010), set `req` = 1010 -> `gnt` = 1000, then 0010 on the next edge.
- **Hold:** `rr_mode` = 1, `hold` = 1, `req` = 0101 -> `gnt` = 0100 for 3 cycles. When `req` changes to 0001 -> `gnt` = 0001 on the next edge.
- **Enable and reset interaction:**
  - `req` = 1111, `en` = 0 for 2 cycles -> `gnt` = 0000 and `ptr` is preserved. With `en` = 1 again, the rotation continues from where it stopped.
  - Asserting `reset` mid-hold -> `gnt` = 0000 at that edge.
- **Self-check:** the bench checks every cycle that `gnt` is one-hot or zero, that `gnt_valid` = |`gnt`, and that `gnt` is a subset of the previous cycle's `req`.
